// File: rtl/float_argmax_pkg.sv
// Shared definitions for the float argmax reduction and its comparator.
package float_argmax_pkg;

  localparam int unsigned FLOAT_W = 32;

  // Bit positions of the comparator flag (a = incoming value, b = running max)
  localparam int unsigned CMP_GT = 2;
  localparam int unsigned CMP_EQ = 1;
  localparam int unsigned CMP_LT = 0;

  localparam logic [2:0] FLAG_GT = 3'b100;

  localparam logic [FLOAT_W-1:0] FLOAT_ZERO    = 32'h0000_0000;
  localparam logic [FLOAT_W-1:0] FLOAT_NEG_INF = 32'hFF80_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/float_argmax_comp_float.sv
// IEEE-754 single-precision comparator producing a one-hot gt/eq/lt flag,
// or all zeros when either operand is NaN (unordered).
module comp_float
  import float_argmax_pkg::*;
(
  output logic [2:0]         flag,
  input  logic [FLOAT_W-1:0] a,
  input  logic [FLOAT_W-1:0] b
);

  logic a_nan;
  logic b_nan;
  logic mag_gt;
  logic a_gt;

  assign a_nan  = (&a[30:23]) & (|a[22:0]);
  assign b_nan  = (&b[30:23]) & (|b[22:0]);
  assign mag_gt = a[30:0] > b[30:0];

  // Sign-magnitude ordering; both zeros are equal regardless of sign
  always_comb begin
    flag = '0;
    a_gt = 1'b0;
    if (a_nan || b_nan) begin
      flag = '0;
    end else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
      flag[CMP_EQ] = 1'b1;
    end else if (a == b) begin
      flag[CMP_EQ] = 1'b1;
    end else begin
      if (a[31] != b[31]) begin
        a_gt = ~a[31];
      end else begin
        a_gt = a[31] ? ~mag_gt : mag_gt;
      end
      flag[CMP_GT] = a_gt;
      flag[CMP_LT] = ~a_gt;
    end
  end

endmodule

// File: rtl/float_argmax.sv
// Streaming argmax over N single-precision values: keeps a running max and
// its index, compared against each accepted beat through one comp_float.
module float_argmax
  import float_argmax_pkg::*;
#(
  parameter int N     = 10,
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FLOAT_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FLOAT_W-1:0] out_max,
  output logic [IDX_W-1:0]   out_idx,
  output logic               busy
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           state;
  logic [IDX_W-1:0] count;
  logic [2:0]       flag;
  logic             accept;

  comp_float u_cmp (
    .flag (flag),
    .a    (in_data),
    .b    (out_max)
  );

  assign accept = in_valid & in_ready;

  // Control FSM with registered handshake outputs and running-max update
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_max   <= FLOAT_ZERO;
      out_idx   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SCAN;
            count    <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (accept) begin
            // First beat seeds the max unconditionally; later beats need strict gt
            if ((count == '0) || (flag == FLAG_GT)) begin
              out_max <= in_data;
              out_idx <= count;
            end
            count <= count + 1'b1;
            if (count == LAST) begin
              state     <= ST_DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_argmax.sv
// Self-checking bench for float_argmax: three builds (N=4, N=3, N=1),
// directed table vectors, hand sequences and randomized reductions.
module tb_float_argmax;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s     [3];
  logic        in_valid_s  [3];
  logic        in_ready_s  [3];
  logic [31:0] in_data_s   [3];
  logic        out_valid_s [3];
  logic        out_ready_s [3];
  logic [31:0] out_max_s   [3];
  logic [3:0]  out_idx_s   [3];
  logic        busy_s      [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  float_argmax #(.N(4), .IDX_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_s[0]), .in_data(in_data_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .out_max(out_max_s[0]), .out_idx(out_idx_s[0]),
    .busy(busy_s[0]));

  float_argmax #(.N(3), .IDX_W(4)) dut3 (
    .clk(clk), .reset(reset), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_s[1]), .in_data(in_data_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .out_max(out_max_s[1]), .out_idx(out_idx_s[1]),
    .busy(busy_s[1]));

  float_argmax #(.N(1), .IDX_W(4)) dut1 (
    .clk(clk), .reset(reset), .start(start_s[2]), .in_valid(in_valid_s[2]),
    .in_ready(in_ready_s[2]), .in_data(in_data_s[2]), .out_valid(out_valid_s[2]),
    .out_ready(out_ready_s[2]), .out_max(out_max_s[2]), .out_idx(out_idx_s[2]),
    .busy(busy_s[2]));

  typedef struct {
    int          d;
    int          n;
    logic [31:0] v [10];
    logic [31:0] emax;
    logic [3:0]  eidx;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: decode to a real number and compare numerically
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic real f2r(input logic [31:0] x);
    real r;
    int  e;
    e = int'(x[30:23]);
    if (e == 255)    r = 1.0e300;
    else if (e == 0) r = real'(x[22:0]) * (2.0 ** (-149));
    else             r = (real'(x[22:0]) + 2.0 ** 23) * (2.0 ** (e - 150));
    return x[31] ? -r : r;
  endfunction

  task automatic model(input int n, input logic [31:0] v[10],
                       output logic [31:0] emax, output logic [3:0] eidx);
    emax = v[0];
    eidx = 4'd0;
    for (int k = 1; k < n; k++) begin
      if (!is_nan(v[k]) && !is_nan(emax) && (f2r(v[k]) > f2r(emax))) begin
        emax = v[k];
        eidx = 4'(k);
      end
    end
  endtask

  function automatic logic [31:0] rnd_float();
    logic [31:0] pool [4];
    logic [31:0] x;
    pool[0] = 32'h3f800000; pool[1] = 32'h40000000;
    pool[2] = 32'hbf800000; pool[3] = 32'h80000000;
    case ($urandom_range(0, 9))
      0: x = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      1: x = {1'($urandom_range(0, 1)), 8'hFF, 23'd0};
      2: x = {1'($urandom_range(0, 1)), 31'd0};
      3, 4: x = pool[$urandom_range(0, 3)];
      5: x = {1'($urandom_range(0, 1)), 8'd0, 23'($urandom_range(1, 32'h7FFFFF))};
      default: x = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)),
                    23'($urandom_range(0, 32'h7FFFFF))};
    endcase
    return x;
  endfunction

  // Full reduction on build d: start, n beats (optional bubbles), hold, consume
  task automatic run(input int d, input int n, input logic [31:0] v[10],
                     input logic [31:0] emax, input logic [3:0] eidx,
                     input logic gaps, input int hold);
    int cnt;
    @(posedge clk); #1 start_s[d] = 1'b1;
    @(posedge clk); #1 start_s[d] = 1'b0;
    chk("busy_scan", 32'(busy_s[d]), 32'd1);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          start_s[d] = 1'b1;
        end
        start_s[d] = 1'b0;
      end
      in_valid_s[d] = 1'b1;
      in_data_s[d]  = v[k];
      cnt = 0;
      while (!in_ready_s[d] && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      chk("in_ready_wait", 32'(in_ready_s[d]), 32'd1);
      if (k == n - 1) chk("no_early_valid", 32'(out_valid_s[d]), 32'd0);
      @(posedge clk); #1 in_valid_s[d] = 1'b0;
    end
    chk("out_valid_latency", 32'(out_valid_s[d]), 32'd1);
    chk("in_ready_done", 32'(in_ready_s[d]), 32'd0);
    chk("out_max", out_max_s[d], emax);
    chk("out_idx", 32'(out_idx_s[d]), 32'(eidx));
    for (int h = 0; h < hold; h++) begin
      start_s[d] = 1'b1;
      in_valid_s[d] = 1'b1;
      in_data_s[d] = 32'h7f7fffff;
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid_s[d]), 32'd1);
      chk("hold_in_ready", 32'(in_ready_s[d]), 32'd0);
      chk("hold_max", out_max_s[d], emax);
      chk("hold_idx", 32'(out_idx_s[d]), 32'(eidx));
    end
    in_valid_s[d]  = 1'b0;
    start_s[d]     = 1'b1;
    out_ready_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d]     = 1'b0;
    out_ready_s[d] = 1'b0;
    chk("consumed_valid", 32'(out_valid_s[d]), 32'd0);
    chk("consumed_busy", 32'(busy_s[d]), 32'd0);
    chk("consumed_in_ready", 32'(in_ready_s[d]), 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    logic [31:0] rv [10];
    logic [31:0] rmax;
    logic [3:0]  ridx;

    foreach (vecs[i]) vecs[i].v = '{default: 32'h0};
    vecs[0].d = 0; vecs[0].n = 4; vecs[0].emax = 32'h40400000; vecs[0].eidx = 4'd1;
    vecs[0].v[0] = 32'h3f800000; vecs[0].v[1] = 32'h40400000;
    vecs[0].v[2] = 32'h40000000; vecs[0].v[3] = 32'hbf800000;
    vecs[1].d = 0; vecs[1].n = 4; vecs[1].emax = 32'h40000000; vecs[1].eidx = 4'd0;
    vecs[1].v[0] = 32'h40000000; vecs[1].v[1] = 32'h40000000;
    vecs[1].v[2] = 32'h80000000; vecs[1].v[3] = 32'h00000000;
    vecs[2].d = 0; vecs[2].n = 4; vecs[2].emax = 32'h80000000; vecs[2].eidx = 4'd0;
    vecs[2].v[0] = 32'h80000000; vecs[2].v[1] = 32'h00000000;
    vecs[2].v[2] = 32'hbf800000; vecs[2].v[3] = 32'hff800000;
    vecs[3].d = 1; vecs[3].n = 3; vecs[3].emax = 32'hbf800000; vecs[3].eidx = 4'd2;
    vecs[3].v[0] = 32'hc0000000; vecs[3].v[1] = 32'h7fc00000;
    vecs[3].v[2] = 32'hbf800000;
    vecs[4].d = 2; vecs[4].n = 1; vecs[4].emax = 32'hc1200000; vecs[4].eidx = 4'd0;
    vecs[4].v[0] = 32'hc1200000;
    vecs[5].d = 0; vecs[5].n = 4; vecs[5].emax = 32'h7f800000; vecs[5].eidx = 4'd1;
    vecs[5].v[0] = 32'hff800000; vecs[5].v[1] = 32'h7f800000;
    vecs[5].v[2] = 32'h7f800000; vecs[5].v[3] = 32'h7f7fffff;

    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0; in_valid_s[d] = 1'b0;
      in_data_s[d] = 32'h0; out_ready_s[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", 32'(in_ready_s[d]), 32'd0);
      chk("rst_out_valid", 32'(out_valid_s[d]), 32'd0);
      chk("rst_out_max", out_max_s[d], 32'h0);
      chk("rst_out_idx", 32'(out_idx_s[d]), 32'd0);
      chk("rst_busy", 32'(busy_s[d]), 32'd0);
    end
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 6; i++)
      run(vecs[i].d, vecs[i].n, vecs[i].v, vecs[i].emax, vecs[i].eidx, 1'b0, 0);

    // Bubbles between beats, 5-cycle DONE stall with start pulses
    run(vecs[0].d, vecs[0].n, vecs[0].v, vecs[0].emax, vecs[0].eidx, 1'b1, 5);

    // Reset mid-SCAN on the N=4 build
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid_s[0] = 1'b1;
      in_data_s[0]  = 32'h7f000000;
      @(posedge clk); #1 in_valid_s[0] = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_in_ready", 32'(in_ready_s[0]), 32'd0);
    chk("abort_busy", 32'(busy_s[0]), 32'd0);
    chk("abort_max", out_max_s[0], 32'h0);
    chk("abort_idx", 32'(out_idx_s[0]), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 32'(out_valid_s[0]), 32'd0);
    end
    rv = '{default: 32'h0};
    rv[0] = 32'h3f800000; rv[1] = 32'h40a00000; rv[2] = 32'h3f800000; rv[3] = 32'h3f800000;
    run(0, 4, rv, 32'h40a00000, 4'd1, 1'b0, 0);

    // Randomized reductions against the numeric model
    for (int it = 0; it < 60; it++) begin
      int d;
      int n;
      d = it % 2;
      n = (d == 0) ? 4 : 3;
      rv = '{default: 32'h0};
      for (int k = 0; k < n; k++) rv[k] = rnd_float();
      model(n, rv, rmax, ridx);
      run(d, n, rv, rmax, ridx, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
